// File: rtl/control_word_sequencer.sv
// Microprogram sequencer: issues LEGv8 control words from a writable store, one per step,
// with a trailing one-cycle datapath tick. Define CWSEQ_DEBOUNCE_EN to debounce the step button.
module control_word_sequencer #(
    parameter int CW_WIDTH        = 40,
    parameter int AW              = 4,
    parameter int RUN_DIV         = 25000000,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    input  logic                abort,
    input  logic                run_mode,
    input  logic                step_n,
    input  logic                prog_we,
    input  logic [AW-1:0]       prog_addr,
    input  logic [CW_WIDTH:0]   prog_data,
    output logic [CW_WIDTH-1:0] control_word,
    output logic                dp_tick,
    output logic [AW-1:0]       upc,
    output logic                busy,
    output logic                done
);
    localparam int CNT_W = 26;
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_DIV - 1);

    typedef enum logic [2:0] {ST_IDLE, ST_ARMED, ST_ISSUE, ST_TICK, ST_HALT} state_t;

    state_t              state_q, state_d;
    logic [CW_WIDTH-1:0] cw_q, cw_d;
    logic [AW-1:0]       upc_q, upc_d;
    logic [AW-1:0]       next_q, next_d;
    logic                end_q, end_d;
    logic                tick_q, tick_d;
    logic [CNT_W-1:0]    rate_cnt_q, rate_cnt_d;

    logic sync1_q, sync2_q, btn_prev_q;
    logic btn_level;
    logic btn_step, rate_step, step_req;

    logic [CW_WIDTH:0] store_mem [2**AW];
    logic [CW_WIDTH:0] rd_word;
    logic              store_we;

    // Button synchronizer; released (high) out of reset so no spurious edge appears.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            btn_prev_q <= 1'b1;
        end else begin
            sync1_q    <= step_n;
            sync2_q    <= sync1_q;
            btn_prev_q <= btn_level;
        end
    end

`ifdef CWSEQ_DEBOUNCE_EN
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             db_level_q, db_level_d;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;

    always_comb begin
        db_level_d = db_level_q;
        db_cnt_d   = '0;
        if (sync2_q != db_level_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_level_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            db_level_q <= 1'b1;
            db_cnt_q   <= '0;
        end else begin
            db_level_q <= db_level_d;
            db_cnt_q   <= db_cnt_d;
        end
    end

    assign btn_level = db_level_q;
`else
    assign btn_level = sync2_q;
`endif

    assign btn_step  = btn_prev_q & ~btn_level;
    assign rate_step = (rate_cnt_q == RUN_LAST);
    assign step_req  = run_mode ? rate_step : btn_step;

    // Rate counter only advances while waiting in ARMED, so each word restarts the interval.
    always_comb begin
        rate_cnt_d = '0;
        if (state_q == ST_ARMED && run_mode && rate_cnt_q != RUN_LAST) begin
            rate_cnt_d = rate_cnt_q + CNT_W'(1);
        end
    end

    assign store_we = prog_we && (state_q == ST_IDLE || state_q == ST_HALT);

    always_ff @(posedge clock) begin
        if (store_we) begin
            store_mem[prog_addr] <= prog_data;
        end
    end

    assign rd_word = store_mem[next_q];

    always_comb begin
        state_d = state_q;
        cw_d    = cw_q;
        upc_d   = upc_q;
        next_d  = next_q;
        end_d   = end_q;
        tick_d  = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
            cw_d    = '0;
            upc_d   = '0;
            next_d  = '0;
            end_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        state_d = ST_ARMED;
                        next_d  = '0;
                    end
                end
                ST_ARMED: begin
                    if (step_req) begin
                        cw_d    = rd_word[CW_WIDTH-1:0];
                        end_d   = rd_word[CW_WIDTH];
                        upc_d   = next_q;
                        state_d = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    tick_d  = 1'b1;
                    state_d = ST_TICK;
                end
                ST_TICK: begin
                    if (end_q || upc_q == {AW{1'b1}}) begin
                        state_d = ST_HALT;
                    end else begin
                        next_d  = upc_q + AW'(1);
                        state_d = ST_ARMED;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cw_q       <= '0;
            upc_q      <= '0;
            next_q     <= '0;
            end_q      <= 1'b0;
            tick_q     <= 1'b0;
            rate_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cw_q       <= cw_d;
            upc_q      <= upc_d;
            next_q     <= next_d;
            end_q      <= end_d;
            tick_q     <= tick_d;
            rate_cnt_q <= rate_cnt_d;
        end
    end

    assign control_word = cw_q;
    assign dp_tick      = tick_q;
    assign upc          = upc_q;
    assign busy         = (state_q == ST_ARMED) || (state_q == ST_ISSUE) || (state_q == ST_TICK);
    assign done         = (state_q == ST_HALT);

endmodule

// File: tb/tb_control_word_sequencer.sv
// Directed bench for control_word_sequencer (RUN_DIV=4, DEBOUNCE_CYCLES=8).
`timescale 1ns/1ps
module tb_control_word_sequencer;
    localparam int CW      = 40;
    localparam int AW      = 4;
    localparam int RUN_DIV = 4;
    localparam int DEB     = 8;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          run_mode = 1'b0;
    logic          step_n = 1'b1;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [CW:0]   prog_data = '0;
    logic [CW-1:0] control_word;
    logic          dp_tick;
    logic [AW-1:0] upc;
    logic          busy;
    logic          done;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int tick_n = 0;
    logic [CW-1:0] tick_cw [256];
    int            tick_cyc [256];

    control_word_sequencer #(
        .CW_WIDTH(CW), .AW(AW), .RUN_DIV(RUN_DIV), .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
        .run_mode(run_mode), .step_n(step_n), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data),
        .control_word(control_word), .dp_tick(dp_tick), .upc(upc),
        .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    // Tick logger: one sample per cycle on the falling edge.
    always @(negedge clock) begin
        cyc++;
        if (dp_tick && tick_n < 256) begin
            tick_cw[tick_n]  = control_word;
            tick_cyc[tick_n] = cyc;
            tick_n++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [CW:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1; tick(); abort = 1'b0;
    endtask

    task automatic wait_done(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            tick();
            if (done === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        total++; if (control_word !== '0) begin bad++; $display("FAIL reset_cw: got %h want 0", control_word); end
        total++; if (dp_tick !== 1'b0) begin bad++; $display("FAIL reset_tick: got %b want 0", dp_tick); end
        total++; if (upc !== '0) begin bad++; $display("FAIL reset_upc: got %0d want 0", upc); end
        total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL reset_busy_done: got %b want 00", {busy, done}); end
        reset_n = 1'b1;
        repeat (2) tick();
        total++; if ({busy, done, dp_tick} !== 3'b000) begin bad++; $display("FAIL idle_after_reset: got %b want 000", {busy, done, dp_tick}); end
        $display("test_reset: done");
    endtask

    task automatic test_run_program();
        logic [CW-1:0] exp_cw [3];
        bit ok;
        int base;
        exp_cw[0] = 40'h01; exp_cw[1] = 40'h02; exp_cw[2] = 40'h03;
        write_word(4'd0, {1'b0, 40'h01});
        write_word(4'd1, {1'b0, 40'h02});
        write_word(4'd2, {1'b1, 40'h03});
        run_mode = 1'b1;
        base = tick_n;
        pulse_start();
        wait_done(200, ok);
        total++; if (!ok) begin bad++; $display("FAIL run_done_timeout: done got %b want 1", done); end
        total++; if (tick_n - base !== 3) begin bad++; $display("FAIL run_tick_count: got %0d want 3", tick_n - base); end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (tick_cw[base+k] !== exp_cw[k]) begin bad++; $display("FAIL run_cw%0d: got %h want %h", k, tick_cw[base+k], exp_cw[k]); end
        end
        for (int k = 1; k < 3; k++) begin
            total++;
            if (tick_cyc[base+k] - tick_cyc[base+k-1] !== RUN_DIV + 2) begin
                bad++; $display("FAIL run_spacing%0d: got %0d want %0d", k, tick_cyc[base+k] - tick_cyc[base+k-1], RUN_DIV + 2);
            end
        end
        total++; if (upc !== 4'd2) begin bad++; $display("FAIL run_halt_upc: got %0d want 2", upc); end
        total++; if (control_word !== 40'h03) begin bad++; $display("FAIL run_halt_cw: got %h want 03", control_word); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL run_halt_busy: got %b want 0", busy); end
        $display("test_run_program: ticks=%0d upc=%0d", tick_n - base, upc);
    endtask

    task automatic test_step_debounce();
        int base;
        int exp_ticks;
        logic [AW-1:0] exp_upc;
        logic exp_done;
`ifdef CWSEQ_DEBOUNCE_EN
        exp_ticks = 1; exp_upc = 4'd0; exp_done = 1'b0;
`else
        exp_ticks = 3; exp_upc = 4'd2; exp_done = 1'b1;
`endif
        run_mode = 1'b0;
        pulse_start();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL step_armed_busy: got %b want 1", busy); end
        base = tick_n;
        for (int b = 0; b < 3; b++) begin
            step_n = 1'b0; tick(); tick();
            step_n = 1'b1; tick(); tick();
        end
        step_n = 1'b0;
        repeat (20) tick();
        step_n = 1'b1;
        repeat (25) tick();
        total++; if (tick_n - base !== exp_ticks) begin bad++; $display("FAIL step_tick_count: got %0d want %0d", tick_n - base, exp_ticks); end
        total++; if (upc !== exp_upc) begin bad++; $display("FAIL step_upc: got %0d want %0d", upc, exp_upc); end
        total++; if (done !== exp_done) begin bad++; $display("FAIL step_done: got %b want %b", done, exp_done); end
        pulse_abort();
        $display("test_step_debounce: ticks=%0d upc=%0d", tick_n - base, upc);
    endtask

    task automatic test_full_program();
        bit ok;
        int base;
        for (int k = 0; k < 16; k++) begin
            write_word(AW'(k), {1'b0, 40'h100 + 40'(k * 17)});
        end
        run_mode = 1'b1;
        base = tick_n;
        pulse_start();
        wait_done(300, ok);
        total++; if (!ok) begin bad++; $display("FAIL full_done_timeout: done got %b want 1", done); end
        total++; if (tick_n - base !== 16) begin bad++; $display("FAIL full_tick_count: got %0d want 16", tick_n - base); end
        total++; if (tick_cw[base] !== 40'h100) begin bad++; $display("FAIL full_first_cw: got %h want 100", tick_cw[base]); end
        total++; if (tick_cw[base+15] !== 40'h1FF) begin bad++; $display("FAIL full_last_cw: got %h want 1ff", tick_cw[base+15]); end
        total++; if (tick_cyc[base+15] - tick_cyc[base] !== 15 * (RUN_DIV + 2)) begin
            bad++; $display("FAIL full_span: got %0d want %0d", tick_cyc[base+15] - tick_cyc[base], 15 * (RUN_DIV + 2));
        end
        total++; if (upc !== 4'd15) begin bad++; $display("FAIL full_upc: got %0d want 15", upc); end
        total++; if (control_word !== 40'h1FF) begin bad++; $display("FAIL full_held_cw: got %h want 1ff", control_word); end
        $display("test_full_program: ticks=%0d upc=%0d", tick_n - base, upc);
    endtask

    task automatic test_abort_start();
        run_mode = 1'b0;
        pulse_start();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_pre_busy: got %b want 1", busy); end
        total++; if (control_word !== 40'h1FF) begin bad++; $display("FAIL abort_pre_cw: got %h want 1ff", control_word); end
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done: got %b want 0", done); end
        total++; if (control_word !== '0) begin bad++; $display("FAIL abort_cw: got %h want 0", control_word); end
        total++; if (upc !== '0) begin bad++; $display("FAIL abort_upc: got %0d want 0", upc); end
        $display("test_abort_start: busy=%b cw=%h", busy, control_word);
    endtask

    task automatic test_prog_while_busy();
        bit ok;
        int base;
        run_mode = 1'b1;
        base = tick_n;
        pulse_start();
        write_word(4'd0, {1'b1, 40'hDEAD});
        wait_done(300, ok);
        total++; if (!ok) begin bad++; $display("FAIL busywr_done_timeout: done got %b want 1", done); end
        total++; if (tick_cw[base] !== 40'h100) begin bad++; $display("FAIL busywr_first_cw: got %h want 100", tick_cw[base]); end
        total++; if (tick_n - base !== 16) begin bad++; $display("FAIL busywr_tick_count: got %0d want 16", tick_n - base); end
        base = tick_n;
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            if (tick_n > base) ok = 1'b1;
        end
        total++; if (!ok) begin bad++; $display("FAIL busywr_restart_timeout: ticks got %0d want >0", tick_n - base); end
        total++; if (tick_cw[base] !== 40'h100) begin bad++; $display("FAIL busywr_restart_cw: got %h want 100", tick_cw[base]); end
        pulse_abort();
        $display("test_prog_while_busy: reissued cw=%h", tick_cw[base]);
    endtask

    task automatic test_reset_mid_tick();
        bit ok;
        int base;
        run_mode = 1'b1;
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            tick();
            if (dp_tick === 1'b1) ok = 1'b1;
        end
        total++; if (!ok) begin bad++; $display("FAIL midtick_timeout: dp_tick got %b want 1", dp_tick); end
        reset_n = 1'b0;
        #1;
        total++; if (control_word !== '0) begin bad++; $display("FAIL midtick_cw: got %h want 0", control_word); end
        total++; if (dp_tick !== 1'b0) begin bad++; $display("FAIL midtick_tick: got %b want 0", dp_tick); end
        total++; if (upc !== '0) begin bad++; $display("FAIL midtick_upc: got %0d want 0", upc); end
        total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL midtick_busy_done: got %b want 00", {busy, done}); end
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midtick_idle: busy got %b want 0", busy); end
        base = tick_n;
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            if (tick_n > base) ok = 1'b1;
        end
        total++; if (!ok) begin bad++; $display("FAIL midtick_restart_timeout: ticks got %0d want >0", tick_n - base); end
        total++; if (tick_cw[base] !== 40'h100) begin bad++; $display("FAIL midtick_retained_cw: got %h want 100", tick_cw[base]); end
        pulse_abort();
        $display("test_reset_mid_tick: retained cw=%h", tick_cw[base]);
    endtask

    initial begin
        test_reset();
        test_run_program();
        test_step_debounce();
        test_full_program();
        test_abort_start();
        test_prog_while_busy();
        test_reset_mid_tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
